// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock alarm blocks.
//   HOUR_W / MIN_W / TIME_W : field widths of a packed {hour, min} time
//   time_t                  : packed {hour, min} time value
//   alarm_state_t           : alarm controller states
//   valid_time()            : true when hour <= 23 and min <= 59
package clock_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int TIME_W = HOUR_W + MIN_W;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
   } time_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   function automatic logic valid_time(input time_t t);
      return (t.hour <= HOUR_W'(23)) && (t.min <= MIN_W'(59));
   endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm time storage and per-slot match detection.
//   clk, rst     : clock, asynchronous active-low reset (slots clear to 00:00)
//   i_time       : running {hour, min}
//   i_edge       : minute edge (time changed this cycle)
//   i_wr         : one-cycle write strobe
//   i_wr_slot    : slot to write
//   i_wr_time    : time to store; out-of-range times are dropped
//   i_en         : per-slot enable mask
//   o_wr_ok      : write strobe carrying a valid time
//   o_match      : per-slot trigger (edge & enable & equal time)
module alarm_slot_bank
   import clock_pkg::*;
#(
   parameter int SLOTS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TIME_W-1:0]        i_time,
   input  logic                     i_edge,
   input  logic                     i_wr,
   input  logic [$clog2(SLOTS)-1:0] i_wr_slot,
   input  logic [TIME_W-1:0]        i_wr_time,
   input  logic [SLOTS-1:0]         i_en,
   output logic                     o_wr_ok,
   output logic [SLOTS-1:0]         o_match
);

   localparam int SLOT_W = $clog2(SLOTS);

   logic [SLOTS-1:0][TIME_W-1:0] r_slot;

   assign o_wr_ok = i_wr && valid_time(time_t'(i_wr_time));

   // Decoded write keeps out-of-range indices (non power-of-two SLOTS) harmless.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot <= '0;
      end else begin
         for (int i = 0; i < SLOTS; i++)
            if (o_wr_ok && (i_wr_slot == SLOT_W'(i)))
               r_slot[i] <= i_wr_time;
      end
   end

   // Match uses the stored value from before a same-cycle write.
   for (genvar g = 0; g < SLOTS; g++) begin : g_match
      assign o_match[g] = i_edge && i_en[g] && (i_time == r_slot[g]);
   end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: arbitrates alarm triggers onto one ring
// output and sequences ring, snooze and ring timeout.
//   clk, rst        : clock, asynchronous active-low reset
//   time_in         : running {hour, min}
//   set_time_in     : alarm time to store, set_slot selects the slot,
//                     set_time is the one-cycle write strobe
//   en_slot         : per-slot enable mask
//   snooze/end_ring : one-cycle user requests (end_ring wins)
//   ring            : alarm sounding (registered)
//   ring_slot       : slot ringing or snoozed (registered, held in IDLE)
//   snooze_active   : high while snoozing (registered)
module alarm_scheduler
   import clock_pkg::*;
#(
   parameter int SLOTS            = 4,
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TIME_W-1:0]        time_in,
   input  logic [TIME_W-1:0]        set_time_in,
   input  logic [$clog2(SLOTS)-1:0] set_slot,
   input  logic                     set_time,
   input  logic [SLOTS-1:0]         en_slot,
   input  logic                     snooze,
   input  logic                     end_ring,
   output logic                     ring,
   output logic [$clog2(SLOTS)-1:0] ring_slot,
   output logic                     snooze_active
);

   localparam int         SLOT_W   = $clog2(SLOTS);
   localparam logic [4:0] TMO_LOAD = 5'(RING_TIMEOUT_MIN);
   localparam logic [4:0] SNZ_LOAD = 5'(SNOOZE_MIN);

   alarm_state_t      r_state, w_state_nxt;
   logic [TIME_W-1:0] r_prev_time;
   logic [SLOTS-1:0]  r_pend, w_pend_nxt;
   logic [4:0]        r_tmo, w_tmo_nxt, w_tmo_dec;
   logic [4:0]        r_snz, w_snz_nxt, w_snz_dec;
   logic [SLOT_W-1:0] r_ring_slot, w_ring_slot_nxt, w_first_idx;
   logic              r_ring, r_snooze_active, w_ring_nxt, w_snooze_nxt;
   logic              w_edge, w_wr_ok, w_act_cancel;
   logic [SLOTS-1:0]  w_match, w_cancel, w_req, w_first_oh, w_act_oh;

   assign w_edge = (time_in != r_prev_time);

   alarm_slot_bank #(.SLOTS(SLOTS)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_time    (time_in),
      .i_edge    (w_edge),
      .i_wr      (set_time),
      .i_wr_slot (set_slot),
      .i_wr_time (set_time_in),
      .i_en      (en_slot),
      .o_wr_ok   (w_wr_ok),
      .o_match   (w_match)
   );

   // A slot is withdrawn when disabled or rewritten.
   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      assign w_cancel[g] = ~en_slot[g] | (w_wr_ok & (set_slot == SLOT_W'(g)));
      assign w_act_oh[g] = (r_ring_slot == SLOT_W'(g));
   end

   assign w_act_cancel = |(w_cancel & w_act_oh);
   assign w_req        = (r_pend | w_match) & ~w_cancel;
   assign w_tmo_dec    = (r_tmo == 5'd0) ? 5'd0 : r_tmo - 5'd1;
   assign w_snz_dec    = (r_snz == 5'd0) ? 5'd0 : r_snz - 5'd1;

   // Lowest-index requester wins.
   always_comb begin
      w_first_idx = '0;
      w_first_oh  = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_first_idx   = SLOT_W'(i);
            w_first_oh    = '0;
            w_first_oh[i] = 1'b1;
         end
      end
   end

   // State register (plus counters, pending mask and registered outputs).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= IDLE;
         r_prev_time     <= '0;
         r_pend          <= '0;
         r_tmo           <= '0;
         r_snz           <= '0;
         r_ring_slot     <= '0;
         r_ring          <= 1'b0;
         r_snooze_active <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_prev_time     <= time_in;
         r_pend          <= w_pend_nxt;
         r_tmo           <= w_tmo_nxt;
         r_snz           <= w_snz_nxt;
         r_ring_slot     <= w_ring_slot_nxt;
         r_ring          <= w_ring_nxt;
         r_snooze_active <= w_snooze_nxt;
      end
   end

   // Next state.
   always_comb begin
      w_state_nxt     = r_state;
      w_tmo_nxt       = r_tmo;
      w_snz_nxt       = r_snz;
      w_ring_slot_nxt = r_ring_slot;
      // While busy, a retrigger of the active slot is dropped.
      w_pend_nxt      = (r_pend | (w_match & ~w_act_oh)) & ~w_cancel;
      case (r_state)
         IDLE: begin
            w_pend_nxt = w_req & ~w_first_oh;
            if (|w_req) begin
               w_state_nxt     = RING;
               w_ring_slot_nxt = w_first_idx;
               w_tmo_nxt       = TMO_LOAD;
            end
         end
         RING: begin
            if (end_ring || w_act_cancel) begin
               w_state_nxt = IDLE;
            end else if (snooze) begin
               w_state_nxt = SNOOZE;
               w_snz_nxt   = SNZ_LOAD;
            end else if (w_edge) begin
               w_tmo_nxt = w_tmo_dec;
               if (w_tmo_dec == 5'd0) w_state_nxt = IDLE;
            end
         end
         SNOOZE: begin
            if (end_ring || w_act_cancel) begin
               w_state_nxt = IDLE;
            end else if (w_edge) begin
               w_snz_nxt = w_snz_dec;
               if (w_snz_dec == 5'd0) begin
                  w_state_nxt = RING;
                  w_tmo_nxt   = TMO_LOAD;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs, decoded from the next state and registered above.
   always_comb begin
      w_ring_nxt   = (w_state_nxt == RING);
      w_snooze_nxt = (w_state_nxt == SNOOZE);
   end

   assign ring          = r_ring;
   assign snooze_active = r_snooze_active;
   assign ring_slot     = r_ring_slot;

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller for the digital clock. It holds SLOTS alarm times and watches the running {hour, min} time bus. It arbitrates simultaneous or overlapping alarms onto the single ring output, and sequences ring, snooze and auto-timeout. It sits between the timekeeping counter, the user set/button logic and the buzzer/LED driver.

Parameters:
SLOTS, 4, number of alarm slots (2..8)
SNOOZE_MIN, 5, minutes between a snooze press and the re-ring (1..31)
RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-stop (1..31)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
time_in  input  11  current time {hour[4:0], min[5:0]}
set_time_in  input  11  alarm time to store {hour, min}
set_slot  input  $clog2(SLOTS)  slot index for set_time
set_time  input  1  one-cycle write strobe
en_slot  input  SLOTS  per-slot enable mask
snooze  input  1  one-cycle snooze request
end_ring  input  1  one-cycle stop request
ring  output  1  alarm sounding
ring_slot  output  $clog2(SLOTS)  slot currently ringing or snoozed
snooze_active  output  1  high while in SNOOZE

Behaviour:
- Reset (rst low, async): state IDLE; ring, snooze_active and ring_slot are 0; all slot times are 00:00; pending mask is 0; prev_time is 0; both counters are 0.
- All outputs are registered. There is no combinational path from input to output.
- Minute edge: asserted in any cycle where time_in != prev_time. prev_time <= time_in every cycle. A manual time jump counts as an edge.
- Trigger: slot i triggers on a minute edge when en_slot[i]=1 and time_in == slot[i].
  - Consequence: a matching time at reset release only triggers if time_in != 00:00.
  - Consequence: staying in a matching minute never retriggers.
- set_time writes set_time_in to slot[set_slot] on the strobe edge. The write is ignored if hour > 23 or min > 59.
- FSM states: IDLE, RING, SNOOZE.
- IDLE:
  - On any trigger or nonzero pending: go to RING. ring_slot = lowest-index requester. Clear that slot's pending bit. Load tmo = RING_TIMEOUT_MIN.
  - ring is high from the edge that first samples the matching time (0-cycle controller latency after sampling).
- RING:
  - end_ring: go to IDLE.
  - Else snooze: go to SNOOZE and load snz = SNOOZE_MIN.
  - Else on a minute edge: tmo decrements. When tmo reaches 0, go to IDLE (auto-stop).
- SNOOZE:
  - ring=0, snooze_active=1.
  - end_ring: go to IDLE (cancel).
  - On a minute edge: snz decrements. When snz reaches 0, go to RING, reload tmo and keep ring_slot.
  - snooze input is ignored in this state.
- Priority: end_ring beats snooze when both arrive in the same cycle.
- Arbitration while busy (RING or SNOOZE):
  - Triggers from other slots set their pending bit.
  - A retrigger of the active slot is dropped.
  - On returning to IDLE, pending slots are served lowest index first, one per IDLE cycle (IDLE lasts exactly 1 cycle).
- Slot cancellation:
  - Clearing en_slot[i], or writing slot i, clears pending[i].
  - If i is the active slot, go to IDLE on the next edge.
- Counters are 5 bits wide and saturate at 0.
- Times are compared as raw 11-bit values. Midnight wrap (23:59 to 00:00) is just another minute edge.

Decomposition:
- Shared package clock_pkg:
  - HOUR_W=5, MIN_W=6, TIME_W=11
  - time_t struct {hour, min}
  - alarm_state_t enum {IDLE, RING, SNOOZE}
  - function valid_time()
- Sub-module alarm_slot_bank:
  - SLOTS registers, write port and validity check.
  - Outputs a SLOTS-bit match vector (enable and equality, gated by the minute edge).
- The FSM, counters, pending mask and priority encoder stay in alarm_scheduler.

Test Plan:
- Slot0 = 08:30, en=0001, time steps 08:28 → 08:30 → ring=1 and ring_slot=0 on the edge sampling 08:30. end_ring → ring=0 next cycle. Holding 08:30 causes no retrigger.
- en=0000, time passes 08:30 → ring stays 0. Write slot0 = 25:10 → slot unchanged (read back 08:30 by hierarchy peek).
- Ring then snooze at 08:31 → snooze_active=1, ring=0. ring reasserts on the edge sampling 08:36. With no input, auto-stop occurs on the edge sampling 08:46 (10 minute edges).
- Slots 1 and 2 both set to 15:45 → ring_slot=1. end_ring → 1 cycle IDLE, then ring_slot=2 with ring=1. Snooze and end_ring in the same cycle → IDLE with no snooze.
- Slot3 = 23:59 ringing, time wraps to 00:00 → tmo decrements. Clear en_slot[3] → ring=0 next edge and pending bit is empty.
- Assert rst low mid-SNOOZE (asynchronous, off the clock edge) → all outputs 0 immediately, slots 00:00. After release, time 00:00 → 00:01 with slot0 = 00:01 and enabled → ring=1.
